md_unit: RTL and testbench

Multiply/divide unit for the E stage of the pipelined MIPS core. It executes mult/multu/div/divu over several cycles and handles mthi/mtlo writes. It holds the architectural HI/LO registers and supplies them to the E/M pipeline register's HI/LO inputs. It raises `busy` so the hazard unit stalls any HI/LO consumer (mfhi/mflo/mult/div/mthi/mtlo) in D until the result is ready.

---
 rtl/md_unit.sv | 129 ++++++++++++
 tb/tb_md_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Purpose : MIPS E-stage multiply/divide unit; holds architectural HI/LO and executes mult/multu/div/divu/mthi/mtlo.
// Latency : mult/multu MULT_CYCLES edges, div/divu DIV_CYCLES edges from accept to HI/LO update; mthi/mtlo update at the accept edge.
// Backpr. : busy/md_stall hold HI/LO consumers in D; a start seen while busy (or flushed by CP0_jump) is dropped, never queued.
// Ports   : clk, reset (async active-low), start/md_op/rs_data/rt_data (request from E), CP0_jump (flush of E),
//           busy (registered in-flight flag), md_stall (combinational stall request), HI/LO (registered architectural regs).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        CP0_jump,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // op_q encoding mirrors md_op[1:0]: bit1 = divide, bit0 = unsigned
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // Datapath is fully combinational on the latched operands; the counter
  // only models the architectural latency.
  logic        is_div, is_signed;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic        div_zero;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'h0, a_q} * {32'h0, b_q};

  // Signed divide via magnitudes: avoids the -2^31 / -1 overflow corner,
  // which naturally yields quotient 0x80000000 and remainder 0.
  assign a_neg    = is_signed & a_q[31];
  assign b_neg    = is_signed & b_q[31];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;
  assign div_zero = (b_q == 32'h0);
  // Keeps the divider input defined on divide-by-zero; result is discarded.
  assign b_safe   = div_zero ? 32'h1 : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem      = a_neg ? -r_mag : r_mag;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (busy_q) begin
      // CP0_jump and start are deliberately ignored here: an accepted op has committed.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (!is_div) begin
          {hi_d, lo_d} = is_signed ? prod_s : prod_u;
        end else if (!div_zero) begin
          hi_d = rem;
          lo_d = quot;
        end
      end
    end else if (start && !CP0_jump) begin
      case (md_op)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          busy_d = 1'b1;
          op_d   = md_op[1:0];
          a_d    = rs_data;
          b_d    = rt_data;
          cnt_d  = md_op[1] ? DIV_LOAD : MULT_LOAD;
        end
        3'd4:    hi_d = rs_data;
        3'd5:    lo_d = rs_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= 2'd0;
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      hi_q   <= 32'h0;
      lo_q   <= 32'h0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // Stall in the accept cycle too, before busy has risen.
  assign md_stall = busy_q | (start & (md_op <= 3'd3) & ~CP0_jump);
  assign busy     = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        CP0_jump;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .CP0_jump (CP0_jump),
    .busy     (busy),
    .md_stall (md_stall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural reference: 64-bit integer arithmetic straight from the ISA rules.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi_m, lo_m} = sp;
      end
      3'd1: begin
        up = 64'(a) * 64'(b);
        {hi_m, lo_m} = up;
      end
      3'd2: if (b != 32'h0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      3'd3: if (b != 32'h0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endfunction

  // mid: 0 nothing, 1 pulse CP0_jump during busy, 2 pulse start (mthi) during busy
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic jump, input int mid);
    int n;
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; CP0_jump = jump;
    #1;
    chk("md_stall_req", {31'h0, md_stall}, {31'h0, (op <= 3'd3) && !jump});
    tick();
    start = 1'b0; CP0_jump = 1'b0; md_op = 3'd7;
    if (!jump && op <= 3'd3) begin
      n = op[1] ? DC : MC;
      for (int k = 0; k < n; k++) begin
        chk("busy_run", {31'h0, busy}, 32'h1);
        chk("stall_run", {31'h0, md_stall}, 32'h1);
        chk("hi_hold", HI, hi_m);
        chk("lo_hold", LO, lo_m);
        if (k == 2 && mid == 1) CP0_jump = 1'b1;
        if (k == 2 && mid == 2) begin
          start = 1'b1; md_op = 3'd4; rs_data = $urandom;
        end
        tick();
        start = 1'b0; CP0_jump = 1'b0; md_op = 3'd7;
      end
      ref_md(op, a, b);
    end else if (!jump) begin
      ref_md(op, a, b);
    end
    chk("busy_done", {31'h0, busy}, 32'h0);
    chk("hi_res", HI, hi_m);
    chk("lo_res", LO, lo_m);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_j;
    int          r_mid;

    reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_data = 32'h0; rt_data = 32'h0; CP0_jump = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
    #12;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_stall", {31'h0, md_stall}, 32'h0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    reset = 1'b1;
    tick();

    // Directed cases with hand-derived results.
    run_op(3'd0, 32'hFFFFFFFF, 32'h2, 1'b0, 0);
    chk("mult_hi", HI, 32'hFFFFFFFF); chk("mult_lo", LO, 32'hFFFFFFFE);
    run_op(3'd1, 32'hFFFFFFFF, 32'h2, 1'b0, 0);
    chk("multu_hi", HI, 32'h00000001); chk("multu_lo", LO, 32'hFFFFFFFE);
    run_op(3'd2, 32'hFFFFFFF9, 32'h2, 1'b0, 0);
    chk("div_hi", HI, 32'hFFFFFFFF); chk("div_lo", LO, 32'hFFFFFFFD);
    run_op(3'd3, 32'h7, 32'h2, 1'b0, 0);
    chk("divu_hi", HI, 32'h1); chk("divu_lo", LO, 32'h3);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1);
    chk("divovf_hi", HI, 32'h0); chk("divovf_lo", LO, 32'h80000000);
    run_op(3'd4, 32'h12345678, 32'h0, 1'b0, 0);
    chk("mthi_hi", HI, 32'h12345678);
    run_op(3'd5, 32'h9ABCDEF0, 32'h0, 1'b0, 0);
    chk("mtlo_hi", HI, 32'h12345678); chk("mtlo_lo", LO, 32'h9ABCDEF0);
    run_op(3'd2, 32'h5, 32'h3, 1'b1, 0);
    chk("flush_hi", HI, 32'h12345678); chk("flush_lo", LO, 32'h9ABCDEF0);
    run_op(3'd4, 32'hA, 32'h0, 1'b0, 0);
    run_op(3'd5, 32'hB, 32'h0, 1'b0, 0);
    run_op(3'd3, 32'h123, 32'h0, 1'b0, 2);
    chk("div0_hi", HI, 32'hA); chk("div0_lo", LO, 32'hB);
    run_op(3'd6, 32'h55, 32'h66, 1'b0, 0);
    chk("nop_hi", HI, 32'hA); chk("nop_lo", LO, 32'hB);

    // Randomized ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'h0;
        1:       r_b = 32'($urandom_range(0, 9)) - 32'd5;
        2:       r_b = 32'hFFFFFFFF;
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) r_a = 32'h80000000;
      r_j   = ($urandom_range(0, 9) == 0);
      r_mid = int'($urandom_range(0, 2));
      run_op(r_op, r_a, r_b, r_j, r_mid);
    end

    // Asynchronous reset in the middle of a mult.
    run_op(3'd4, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    run_op(3'd5, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    start = 1'b1; md_op = 3'd0; rs_data = 32'h3; rt_data = 32'h4;
    tick();
    start = 1'b0; md_op = 3'd7;
    tick();
    tick();
    chk("pre_arst_busy", {31'h0, busy}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_hi", HI, 32'h0);
    chk("arst_lo", LO, 32'h0);
    hi_m = 32'h0; lo_m = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_arst_busy", {31'h0, busy}, 32'h0);
      chk("post_arst_hi", HI, 32'h0);
      chk("post_arst_lo", LO, 32'h0);
    end
    run_op(3'd0, 32'h3, 32'h4, 1'b0, 0);
    chk("post_arst_mult", LO, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
